// File: rtl/pwm_channel_sequencer.sv
// Channel sequencer for a shared PWM generator: debounced channel select, quadrature
// encoder duty adjust per channel, and compare-word hand-off aligned to period boundaries.

module pwm_seq_debounce (
  input  logic CLK,
  input  logic RESET_N,
  input  logic tick_i,
  input  logic lvl_i,
  output logic press_o
);
  logic smp_q, deb_q, deb_d;

  // A level is accepted only once it has been seen on two consecutive ticks.
  always_comb begin
    deb_d = deb_q;
    if (tick_i && (lvl_i == smp_q)) deb_d = lvl_i;
  end

  assign press_o = deb_d & ~deb_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      smp_q <= 1'b0;
      deb_q <= 1'b0;
    end else begin
      if (tick_i) smp_q <= lvl_i;
      deb_q <= deb_d;
    end
  end
endmodule

module pwm_channel_sequencer #(
  parameter int DEB_COUNT = 2_500_000,
  parameter int ENC_COUNT = 32_000,
  parameter int STEP      = 1,
  parameter int DUTY_MAX  = 255,
  parameter int DUTY_INIT = 0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENC_A,
  input  logic        ENC_B,
  input  logic        BOTON_MR,
  input  logic        BOTON_MDC,
  input  logic        BOTON_LED,
  input  logic        PERIOD_END,
  output logic [18:0] PWM,
  output logic        PWM_LOAD,
  output logic [1:0]  BOTON_SEL,
  output logic [7:0]  DUTY
);
  localparam int NUM_CH = 3;
  localparam int DW     = $clog2(DEB_COUNT + 1);
  localparam int EW     = $clog2(ENC_COUNT + 1);
  localparam logic [9:0] STEP_W = 10'(STEP);
  localparam logic [9:0] MAX_W  = 10'(DUTY_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOAD} state_t;

  // Synchronisers: bit order {A, B, LED, MDC, MR}
  logic [4:0] s1_q, s2_q;
  logic [NUM_CH-1:0] btn_s, press;
  logic [1:0] enc_s;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {ENC_A, ENC_B, BOTON_LED, BOTON_MDC, BOTON_MR};
      s2_q <= s1_q;
    end
  end

  assign btn_s = s2_q[2:0];
  assign enc_s = s2_q[4:3];

  // Sample-interval counters
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [EW-1:0] enc_cnt_q, enc_cnt_d;
  logic deb_tick, enc_tick;

  assign deb_tick  = (deb_cnt_q == DW'(DEB_COUNT));
  assign enc_tick  = (enc_cnt_q == EW'(ENC_COUNT));
  assign deb_cnt_d = deb_tick ? '0 : deb_cnt_q + DW'(1);
  assign enc_cnt_d = enc_tick ? '0 : enc_cnt_q + EW'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
    pwm_seq_debounce u_deb (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .tick_i  (deb_tick),
      .lvl_i   (btn_s[g]),
      .press_o (press[g])
    );
  end

  logic [1:0] sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if      (press[0]) sel_d = 2'b01;
    else if (press[1]) sel_d = 2'b11;
    else if (press[2]) sel_d = 2'b10;
  end

  // Encoder: Gray-to-binary position, forward distance 1 = CW, 3 = CCW, 2 = illegal jump
  logic [1:0] enc_smp_q, enc_smp_d, pos_cur, pos_prv, pos_diff;
  logic enc_cw, enc_ccw;

  assign pos_cur   = {enc_s[1], enc_s[1] ^ enc_s[0]};
  assign pos_prv   = {enc_smp_q[1], enc_smp_q[1] ^ enc_smp_q[0]};
  assign pos_diff  = pos_cur - pos_prv;
  assign enc_cw    = enc_tick && (pos_diff == 2'd1);
  assign enc_ccw   = enc_tick && (pos_diff == 2'd3);
  assign enc_smp_d = enc_tick ? enc_s : enc_smp_q;

  // Per-channel duty registers, index 0 MR, 1 MDC, 2 LED
  logic [NUM_CH-1:0][7:0] duty_q, duty_d;
  logic [7:0] duty_sel, inc_sat, dec_sat;
  logic [9:0] inc_w;
  logic [1:0] ch_idx;
  logic ch_vld;

  always_comb begin
    ch_vld = 1'b1;
    ch_idx = 2'd0;
    case (sel_q)
      2'b01:   ch_idx = 2'd0;
      2'b11:   ch_idx = 2'd1;
      2'b10:   ch_idx = 2'd2;
      default: ch_vld = 1'b0;
    endcase
  end

  assign duty_sel = ch_vld ? duty_q[ch_idx] : 8'd0;
  assign inc_w    = {2'b00, duty_sel} + STEP_W;
  assign inc_sat  = (inc_w > MAX_W) ? MAX_W[7:0] : inc_w[7:0];
  assign dec_sat  = ({2'b00, duty_sel} < STEP_W) ? 8'd0 : duty_sel - STEP_W[7:0];

  // Uses sel_q, so a step coinciding with a select press lands on the old channel.
  always_comb begin
    duty_d = duty_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_vld && (ch_idx == 2'(i)) && (enc_cw || enc_ccw))
        duty_d[i] = enc_cw ? inc_sat : dec_sat;
    end
  end

  logic [18:0] target, pwm_q, pwm_d;
  state_t state_q, state_d;

  assign target = ch_vld ? {1'b0, duty_sel, 10'd1} : 19'd0;

  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    case (state_q)
      S_IDLE:  if (target != pwm_q) state_d = S_ARMED;
      S_ARMED: if (PERIOD_END) begin
        state_d = S_LOAD;
        pwm_d   = target;
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_cnt_q <= '0;
      enc_cnt_q <= '0;
      enc_smp_q <= '0;
      sel_q     <= 2'b00;
      duty_q    <= {NUM_CH{8'(DUTY_INIT)}};
      pwm_q     <= '0;
      state_q   <= S_IDLE;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      enc_cnt_q <= enc_cnt_d;
      enc_smp_q <= enc_smp_d;
      sel_q     <= sel_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      state_q   <= state_d;
    end
  end

  assign PWM       = pwm_q;
  assign PWM_LOAD  = (state_q == S_LOAD);
  assign BOTON_SEL = sel_q;
  assign DUTY      = duty_sel;
endmodule

// File: tb/tb_pwm_channel_sequencer.sv
// Bench for pwm_channel_sequencer: directed scenarios plus a randomized encoder/select
// sequence checked against a channel/duty model kept here.

module tb_pwm_channel_sequencer;
  logic CLK = 1'b0, RESET_N = 1'b0;
  logic ENC_A = 1'b0, ENC_B = 1'b0;
  logic BOTON_MR = 1'b0, BOTON_MDC = 1'b0, BOTON_LED = 1'b0, PERIOD_END = 1'b0;
  logic [18:0] PWM;
  logic PWM_LOAD;
  logic [1:0] BOTON_SEL;
  logic [7:0] DUTY;

  int n_tests = 0, n_fail = 0, load_cnt = 0;
  int m_ch = -1;
  int m_duty[3] = '{0, 0, 0};
  int m_idx = 0;
  logic [1:0] gray_seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  pwm_channel_sequencer #(.DEB_COUNT(4), .ENC_COUNT(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENC_A(ENC_A), .ENC_B(ENC_B),
    .BOTON_MR(BOTON_MR), .BOTON_MDC(BOTON_MDC), .BOTON_LED(BOTON_LED),
    .PERIOD_END(PERIOD_END), .PWM(PWM), .PWM_LOAD(PWM_LOAD),
    .BOTON_SEL(BOTON_SEL), .DUTY(DUTY)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (PWM_LOAD) load_cnt++;

  function automatic logic [1:0] exp_sel();
    case (m_ch)
      0: return 2'b01;
      1: return 2'b11;
      2: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] exp_duty();
    return (m_ch < 0) ? 8'd0 : 8'(m_duty[m_ch]);
  endfunction

  function automatic logic [18:0] exp_target();
    return (m_ch < 0) ? 19'd0 : {1'b0, 8'(m_duty[m_ch]), 10'd1};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // kind 0 CW, 1 CCW, 2 diagonal jump (ignored by the design)
  task automatic enc_step(input int kind);
    int v;
    m_idx = (kind == 0) ? (m_idx + 1) % 4 : (kind == 1) ? (m_idx + 3) % 4 : (m_idx + 2) % 4;
    {ENC_A, ENC_B} = gray_seq[m_idx];
    cyc(8);
    if (m_ch >= 0 && kind < 2) begin
      v = m_duty[m_ch] + ((kind == 0) ? 1 : -1);
      m_duty[m_ch] = (v < 0) ? 0 : (v > 255) ? 255 : v;
    end
  endtask

  task automatic press(input bit mr, input bit mdc, input bit led);
    BOTON_MR = mr; BOTON_MDC = mdc; BOTON_LED = led;
    cyc(20);
    BOTON_MR = 1'b0; BOTON_MDC = 1'b0; BOTON_LED = 1'b0;
    cyc(20);
    if (mr) m_ch = 0; else if (mdc) m_ch = 1; else if (led) m_ch = 2;
  endtask

  task automatic pulse_period_end();
    PERIOD_END = 1'b1;
    cyc(1);
    PERIOD_END = 1'b0;
  endtask

  task automatic test_reset();
    int lc;
    RESET_N = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {ENC_A, ENC_B, BOTON_MR, BOTON_MDC, BOTON_LED, PERIOD_END} = 6'($urandom);
      cyc(1);
    end
    n_tests++; if (PWM !== 19'd0) begin n_fail++; $display("FAIL reset_pwm: got %h exp 0", PWM); end
    n_tests++; if (PWM_LOAD !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b exp 0", PWM_LOAD); end
    n_tests++; if (BOTON_SEL !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b exp 00", BOTON_SEL); end
    n_tests++; if (DUTY !== 8'd0) begin n_fail++; $display("FAIL reset_duty: got %0d exp 0", DUTY); end
    {ENC_A, ENC_B, BOTON_MR, BOTON_MDC, BOTON_LED, PERIOD_END} = '0;
    cyc(3);
    RESET_N = 1'b1;
    lc = load_cnt;
    cyc(100);
    n_tests++; if (load_cnt !== lc) begin n_fail++; $display("FAIL idle_no_load: got %0d loads exp 0", load_cnt - lc); end
    n_tests++; if (PWM !== 19'd0) begin n_fail++; $display("FAIL idle_pwm: got %h exp 0", PWM); end
  endtask

  task automatic test_debounce();
    BOTON_MDC = 1'b1;
    cyc(3);
    BOTON_MDC = 1'b0;
    cyc(20);
    n_tests++; if (BOTON_SEL !== 2'b00) begin n_fail++; $display("FAIL glitch_sel: got %b exp 00", BOTON_SEL); end
    press(0, 1, 0);
    n_tests++; if (BOTON_SEL !== exp_sel()) begin n_fail++; $display("FAIL mdc_sel: got %b exp %b", BOTON_SEL, exp_sel()); end
    press(1, 0, 1);
    n_tests++; if (BOTON_SEL !== 2'b01) begin n_fail++; $display("FAIL prio_sel: got %b exp 01", BOTON_SEL); end
  endtask

  task automatic test_encoder_sat();
    press(0, 0, 1);
    n_tests++; if (BOTON_SEL !== 2'b10) begin n_fail++; $display("FAIL led_sel: got %b exp 10", BOTON_SEL); end
    repeat (3) enc_step(0);
    n_tests++; if (DUTY !== 8'd3) begin n_fail++; $display("FAIL cw3: got %0d exp 3", DUTY); end
    repeat (5) enc_step(1);
    n_tests++; if (DUTY !== 8'd0) begin n_fail++; $display("FAIL ccw_floor: got %0d exp 0", DUTY); end
    enc_step(2);
    n_tests++; if (DUTY !== 8'd0) begin n_fail++; $display("FAIL jump_ignored: got %0d exp 0", DUTY); end
    repeat (254) enc_step(0);
    n_tests++; if (DUTY !== 8'd254) begin n_fail++; $display("FAIL preload254: got %0d exp 254", DUTY); end
    repeat (3) enc_step(0);
    n_tests++; if (DUTY !== 8'd255) begin n_fail++; $display("FAIL cw_ceiling: got %0d exp 255", DUTY); end
  endtask

  task automatic test_retention();
    press(1, 0, 0);
    repeat (10) enc_step(0);
    n_tests++; if (DUTY !== 8'd10) begin n_fail++; $display("FAIL mr_duty: got %0d exp 10", DUTY); end
    press(0, 1, 0);
    repeat (4) enc_step(0);
    n_tests++; if (DUTY !== 8'd4) begin n_fail++; $display("FAIL mdc_duty: got %0d exp 4", DUTY); end
    press(1, 0, 0);
    n_tests++; if (DUTY !== 8'd10) begin n_fail++; $display("FAIL mr_retained: got %0d exp 10", DUTY); end
  endtask

  task automatic test_period_load();
    int lc;
    lc = load_cnt;
    cyc(50);
    n_tests++; if (PWM !== 19'd0) begin n_fail++; $display("FAIL pwm_held: got %h exp 0", PWM); end
    pulse_period_end();
    n_tests++; if (PWM !== 19'h02801) begin n_fail++; $display("FAIL pwm_loaded: got %h exp 02801", PWM); end
    n_tests++; if (PWM_LOAD !== 1'b1) begin n_fail++; $display("FAIL load_strobe: got %b exp 1", PWM_LOAD); end
    cyc(1);
    n_tests++; if (PWM_LOAD !== 1'b0) begin n_fail++; $display("FAIL load_width: got %b exp 0", PWM_LOAD); end
    cyc(20);
    n_tests++; if (load_cnt - lc !== 1) begin n_fail++; $display("FAIL load_count: got %0d exp 1", load_cnt - lc); end
  endtask

  task automatic test_late_change();
    int lc;
    enc_step(0);
    enc_step(0);
    n_tests++; if (DUTY !== 8'd12) begin n_fail++; $display("FAIL late_duty: got %0d exp 12", DUTY); end
    n_tests++; if (PWM !== 19'h02801) begin n_fail++; $display("FAIL late_pwm_hold: got %h exp 02801", PWM); end
    pulse_period_end();
    n_tests++; if (PWM !== 19'h03001) begin n_fail++; $display("FAIL late_loaded: got %h exp 03001", PWM); end
    n_tests++; if (PWM_LOAD !== 1'b1) begin n_fail++; $display("FAIL late_strobe: got %b exp 1", PWM_LOAD); end
    enc_step(0);
    lc = load_cnt;
    RESET_N = 1'b0;
    cyc(3);
    n_tests++; if (PWM !== 19'd0) begin n_fail++; $display("FAIL armed_reset_pwm: got %h exp 0", PWM); end
    n_tests++; if (BOTON_SEL !== 2'b00) begin n_fail++; $display("FAIL armed_reset_sel: got %b exp 00", BOTON_SEL); end
    RESET_N = 1'b1;
    m_ch = -1;
    m_duty = '{0, 0, 0};
    cyc(10);
    pulse_period_end();
    cyc(5);
    n_tests++; if (load_cnt !== lc) begin n_fail++; $display("FAIL aborted_load: got %0d loads exp 0", load_cnt - lc); end
    n_tests++; if (PWM !== 19'd0) begin n_fail++; $display("FAIL aborted_pwm: got %h exp 0", PWM); end
  endtask

  task automatic test_random();
    int r, c;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      if (r < 2) enc_step(0);
      else if (r < 4) enc_step(1);
      else if (r == 4) enc_step(2);
      else begin
        c = $urandom_range(0, 2);
        press(c == 0, c == 1, c == 2);
      end
      n_tests++; if (BOTON_SEL !== exp_sel()) begin n_fail++; $display("FAIL rnd_sel[%0d]: got %b exp %b", i, BOTON_SEL, exp_sel()); end
      n_tests++; if (DUTY !== exp_duty()) begin n_fail++; $display("FAIL rnd_duty[%0d]: got %0d exp %0d", i, DUTY, exp_duty()); end
    end
    pulse_period_end();
    n_tests++; if (PWM !== exp_target()) begin n_fail++; $display("FAIL rnd_pwm: got %h exp %h", PWM, exp_target()); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_encoder_sat();
    test_retention();
    test_period_load();
    test_late_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
